// File: rtl/rob_retire_pkg.sv
// Shared constants and the entry record for the reorder buffer.
//   ROB_DEPTH / ROB_IDX_LEN : entry count (power of two) and entry id width
//   DISP_WIDTH / NUM_WB     : dispatch lanes and writeback ports per cycle
//   ROB_MAX_RETIRE          : retire slots per cycle
//   SRC_LEN / DATA_LEN      : register index and data widths
package rob_retire_pkg;
    localparam int ROB_DEPTH      = 16;
    localparam int ROB_IDX_LEN    = $clog2(ROB_DEPTH);
    localparam int CNT_W          = ROB_IDX_LEN + 1;
    localparam int DISP_WIDTH     = 2;
    localparam int NUM_WB         = 2;
    localparam int ROB_MAX_RETIRE = 2;
    localparam int SRC_LEN        = 5;
    localparam int DATA_LEN       = 32;
    localparam int RET_CNT_W      = $clog2(ROB_MAX_RETIRE + 1);
    localparam int ALLOC_W        = $clog2(DISP_WIDTH + 1);

    typedef struct packed {
        logic                valid;
        logic                done;
        logic                rfWrite;
        logic [SRC_LEN-1:0]  rd;
        logic [DATA_LEN-1:0] data;
    } rob_entry_t;
endpackage

// File: rtl/rob_retire_sel.sv
// Retire selection: walks the entries starting at head and marks the
// leading run of valid+done entries, capped at ROB_MAX_RETIRE.
//   head     : oldest entry id
//   entries  : full entry array
//   elig     : per-slot eligible mask (always a contiguous run from slot 0)
//   ret_cnt  : number of eligible slots
//   slot_ent : entry seen by each slot, used to build the retire outputs
module rob_retire_sel
    import rob_retire_pkg::*;
(
    input  logic [ROB_IDX_LEN-1:0]                 head,
    input  rob_entry_t [ROB_DEPTH-1:0]             entries,
    output logic [ROB_MAX_RETIRE-1:0]              elig,
    output logic [RET_CNT_W-1:0]                   ret_cnt,
    output rob_entry_t [ROB_MAX_RETIRE-1:0]        slot_ent
);
    for (genvar j = 0; j < ROB_MAX_RETIRE; j++) begin : g_slot
        assign slot_ent[j] = entries[head + ROB_IDX_LEN'(j)];
    end

    // A slot is eligible only while every older slot is; the first
    // not-done entry blocks everything behind it.
    always_comb begin
        logic run;
        run     = 1'b1;
        elig    = '0;
        ret_cnt = '0;
        for (int j = 0; j < ROB_MAX_RETIRE; j++) begin
            run     = run & slot_ent[j].valid & slot_ent[j].done;
            elig[j] = run;
            ret_cnt = ret_cnt + RET_CNT_W'(run);
        end
    end
endmodule

// File: rtl/rob_retire.sv
// In-order reorder buffer: allocates at dispatch, marks entries done on
// writeback (any order), retires up to ROB_MAX_RETIRE done head entries
// per cycle onto registered register-file write ports.
//   clk, rst_n (async low), flush (sync, empties the buffer)
//   disp_val/disp_rd/disp_rfWrite : dispatch lanes, packed from lane 0
//   disp_rob_id                   : id allocated per lane (combinational)
//   rob_alloc_rdy                 : room for a full dispatch group
//   wb_val/wb_rob_id/wb_data      : writeback ports
//   val_ret/rd_ret/rfWrite_ret/wb_data_ret : registered retire slots
//   rob_empty, rob_count          : occupancy
module rob_retire
    import rob_retire_pkg::*;
(
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     flush,
    input  logic [DISP_WIDTH-1:0]                    disp_val,
    input  logic [DISP_WIDTH-1:0][SRC_LEN-1:0]       disp_rd,
    input  logic [DISP_WIDTH-1:0]                    disp_rfWrite,
    output logic [DISP_WIDTH-1:0][ROB_IDX_LEN-1:0]   disp_rob_id,
    output logic                                     rob_alloc_rdy,
    input  logic [NUM_WB-1:0]                        wb_val,
    input  logic [NUM_WB-1:0][ROB_IDX_LEN-1:0]       wb_rob_id,
    input  logic [NUM_WB-1:0][DATA_LEN-1:0]          wb_data,
    output logic [ROB_MAX_RETIRE-1:0]                val_ret,
    output logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0]   rd_ret,
    output logic [ROB_MAX_RETIRE-1:0]                rfWrite_ret,
    output logic [ROB_MAX_RETIRE-1:0][DATA_LEN-1:0]  wb_data_ret,
    output logic                                     rob_empty,
    output logic [CNT_W-1:0]                         rob_count
);
    rob_entry_t [ROB_DEPTH-1:0]      entries;
    logic [ROB_IDX_LEN-1:0]          head, tail;
    logic [CNT_W-1:0]                count;
    logic [ROB_MAX_RETIRE-1:0]       elig;
    logic [RET_CNT_W-1:0]            ret_cnt;
    rob_entry_t [ROB_MAX_RETIRE-1:0] slot_ent;
    logic [DISP_WIDTH-1:0]           alloc;
    logic [ALLOC_W-1:0]              alloc_n;

    rob_retire_sel u_sel (
        .head     (head),
        .entries  (entries),
        .elig     (elig),
        .ret_cnt  (ret_cnt),
        .slot_ent (slot_ent)
    );

    // Readiness comes from the registered count only; retirement in the
    // same cycle does not free room for this cycle's dispatch.
    assign rob_alloc_rdy = (CNT_W'(ROB_DEPTH) - count) >= CNT_W'(DISP_WIDTH);
    assign rob_empty     = (count == '0);
    assign rob_count     = count;
    assign alloc         = disp_val & {DISP_WIDTH{rob_alloc_rdy}};

    for (genvar i = 0; i < DISP_WIDTH; i++) begin : g_lane
        assign disp_rob_id[i] = tail + ROB_IDX_LEN'(i);
    end

    always_comb begin
        alloc_n = '0;
        for (int i = 0; i < DISP_WIDTH; i++) alloc_n = alloc_n + ALLOC_W'(alloc[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries     <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            val_ret     <= '0;
            rd_ret      <= '0;
            rfWrite_ret <= '0;
            wb_data_ret <= '0;
        end else if (flush) begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                entries[e].valid <= 1'b0;
                entries[e].done  <= 1'b0;
            end
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            val_ret     <= '0;
            rd_ret      <= '0;
            rfWrite_ret <= '0;
            wb_data_ret <= '0;
        end else begin
            // Order matters: writeback, then retire invalidate, then allocate.
            // Allocation only touches entries that were invalid before the edge.
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_val[k] && entries[wb_rob_id[k]].valid) begin
                    entries[wb_rob_id[k]].data <= wb_data[k];
                    entries[wb_rob_id[k]].done <= 1'b1;
                end
            end
            for (int j = 0; j < ROB_MAX_RETIRE; j++) begin
                if (elig[j]) entries[head + ROB_IDX_LEN'(j)].valid <= 1'b0;
            end
            for (int i = 0; i < DISP_WIDTH; i++) begin
                if (alloc[i]) begin
                    entries[tail + ROB_IDX_LEN'(i)] <= '{valid: 1'b1, done: 1'b0,
                        rfWrite: disp_rfWrite[i], rd: disp_rd[i], data: '0};
                end
            end
            head    <= head + ROB_IDX_LEN'(ret_cnt);
            tail    <= tail + ROB_IDX_LEN'(alloc_n);
            count   <= count + CNT_W'(alloc_n) - CNT_W'(ret_cnt);
            val_ret <= elig;
            for (int j = 0; j < ROB_MAX_RETIRE; j++) begin
                rd_ret[j]      <= elig[j] ? slot_ent[j].rd      : '0;
                rfWrite_ret[j] <= elig[j] ? slot_ent[j].rfWrite : 1'b0;
                wb_data_ret[j] <= elig[j] ? slot_ent[j].data    : '0;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && !flush) begin
            assert ((disp_val & (disp_val + DISP_WIDTH'(1))) == '0)
                else $error("dispatch lanes not packed");
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_val[k]) assert (entries[wb_rob_id[k]].valid)
                    else $error("writeback to invalid entry");
                for (int l = k + 1; l < NUM_WB; l++) begin
                    assert (!(wb_val[k] && wb_val[l] && wb_rob_id[k] == wb_rob_id[l]))
                        else $error("two writebacks to one entry");
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_rob_retire.sv
module tb_rob_retire;
    import rob_retire_pkg::*;

    logic clk = 1'b0;
    logic rst_n, flush;
    logic [DISP_WIDTH-1:0]                   disp_val, disp_rfWrite;
    logic [DISP_WIDTH-1:0][SRC_LEN-1:0]      disp_rd;
    logic [DISP_WIDTH-1:0][ROB_IDX_LEN-1:0]  disp_rob_id;
    logic                                    rob_alloc_rdy, rob_empty;
    logic [NUM_WB-1:0]                       wb_val;
    logic [NUM_WB-1:0][ROB_IDX_LEN-1:0]      wb_rob_id;
    logic [NUM_WB-1:0][DATA_LEN-1:0]         wb_data;
    logic [ROB_MAX_RETIRE-1:0]               val_ret, rfWrite_ret;
    logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0]  rd_ret;
    logic [ROB_MAX_RETIRE-1:0][DATA_LEN-1:0] wb_data_ret;
    logic [CNT_W-1:0]                        rob_count;

    always #5 clk = ~clk;

    rob_retire dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_val(disp_val), .disp_rd(disp_rd), .disp_rfWrite(disp_rfWrite),
        .disp_rob_id(disp_rob_id), .rob_alloc_rdy(rob_alloc_rdy),
        .wb_val(wb_val), .wb_rob_id(wb_rob_id), .wb_data(wb_data),
        .val_ret(val_ret), .rd_ret(rd_ret), .rfWrite_ret(rfWrite_ret),
        .wb_data_ret(wb_data_ret), .rob_empty(rob_empty), .rob_count(rob_count)
    );

    // Reference model: program-order list of in-flight instructions.
    typedef struct {
        logic [SRC_LEN-1:0]  rd;
        logic                rfw;
        logic [DATA_LEN-1:0] data;
        bit                  done;
    } m_t;
    m_t q[$];
    m_t sb[$];
    int h = 0, t = 0, last_nr = 0;
    int total = 0, bad = 0;

    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", n, a, e);
        end
    endfunction

    task automatic step(int nd, logic [4:0] r0, logic [4:0] r1, logic [1:0] rfw,
                        logic [1:0] wv, int i0, int i1, logic [31:0] d0, logic [31:0] d1, bit fl);
        int nr;
        bit rdy;
        int idx;
        int ids[2];
        logic [31:0] ds[2];
        @(negedge clk);
        chk("count", 64'(rob_count), 64'(q.size()));
        chk("empty", 64'(rob_empty), 64'(q.size() == 0));
        chk("alloc_rdy", 64'(rob_alloc_rdy), 64'((ROB_DEPTH - q.size()) >= DISP_WIDTH));
        chk("val_ret", 64'(val_ret), 64'((1 << last_nr) - 1));
        disp_val     = (nd == 2) ? 2'b11 : (nd == 1) ? 2'b01 : 2'b00;
        disp_rd[0]   = r0;
        disp_rd[1]   = r1;
        disp_rfWrite = rfw;
        wb_val       = wv;
        wb_rob_id[0] = ROB_IDX_LEN'(i0);
        wb_rob_id[1] = ROB_IDX_LEN'(i1);
        wb_data[0]   = d0;
        wb_data[1]   = d1;
        flush        = fl;
        #1;
        for (int i = 0; i < nd; i++) chk("disp_id", 64'(disp_rob_id[i]), 64'((t + i) % ROB_DEPTH));
        nr = 0;
        if (fl) begin
            q.delete();
            h = 0;
            t = 0;
        end else begin
            rdy = (ROB_DEPTH - q.size()) >= DISP_WIDTH;
            while (nr < ROB_MAX_RETIRE && nr < q.size() && q[nr].done) nr++;
            ids[0] = i0; ids[1] = i1; ds[0] = d0; ds[1] = d1;
            for (int k = 0; k < NUM_WB; k++) begin
                if (wv[k]) begin
                    idx = (ids[k] - h + ROB_DEPTH) % ROB_DEPTH;
                    if (idx < q.size()) begin
                        q[idx].done = 1;
                        q[idx].data = ds[k];
                    end
                end
            end
            for (int r = 0; r < nr; r++) sb.push_back(q.pop_front());
            h = (h + nr) % ROB_DEPTH;
            if (rdy) begin
                if (nd > 0) q.push_back('{rd: r0, rfw: rfw[0], data: 0, done: 0});
                if (nd > 1) q.push_back('{rd: r1, rfw: rfw[1], data: 0, done: 0});
                t = (t + nd) % ROB_DEPTH;
            end
        end
        last_nr = nr;
        @(posedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic disp(int nd, logic [4:0] r0, logic [4:0] r1, logic [1:0] rfw);
        step(nd, r0, r1, rfw, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wb1(int id, logic [31:0] d);
        step(0, 0, 0, 0, 2'b01, id, 0, d, 0, 0);
    endtask

    task automatic do_reset();
        disp_val = 0; wb_val = 0; flush = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_val_ret", 64'(val_ret), 0);
        chk("rst_empty", 64'(rob_empty), 1);
        chk("rst_count", 64'(rob_count), 0);
        chk("rst_rdy", 64'(rob_alloc_rdy), 1);
        q.delete(); sb.delete();
        h = 0; t = 0; last_nr = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every presented retire slot is matched against the oldest
    // expected retirement; idle slots must be driven to zero.
    initial begin
        m_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                for (int j = 0; j < ROB_MAX_RETIRE; j++) begin
                    if (val_ret[j]) begin
                        if (sb.size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_retire slot=%0d act_rd=%0d exp=none", j, rd_ret[j]);
                        end else begin
                            e = sb.pop_front();
                            chk("ret_rd", 64'(rd_ret[j]), 64'(e.rd));
                            chk("ret_rfw", 64'(rfWrite_ret[j]), 64'(e.rfw));
                            chk("ret_data", 64'(wb_data_ret[j]), 64'(e.data));
                        end
                    end else begin
                        chk("idle_slot", 64'({rd_ret[j], rfWrite_ret[j], wb_data_ret[j]}), 0);
                    end
                end
            end
        end
    end

    initial begin
        int cand[$];
        int nd, a, b, ca, cb;
        logic [1:0] wv;
        rst_n = 1'b0; flush = 0; disp_val = 0; disp_rd = '0; disp_rfWrite = 0;
        wb_val = 0; wb_rob_id = '0; wb_data = '0;
        #12;
        do_reset();

        // Out-of-order completion, in-order dual retire.
        disp(2, 5, 6, 2'b11);
        wb1(1, 32'hBBBB);
        wb1(0, 32'hAAAA);
        idle(3);
        chk("empty_after_pair", 64'(rob_empty), 1);

        // Younger done, older pending: nothing may retire.
        disp(2, 7, 8, 2'b11);
        wb1(3, 32'h1111);
        idle(5);
        wb1(2, 32'h2222);
        idle(3);

        // Fill to full, then free two at the head and wrap the tail.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) disp(2, 5'(i), 5'(i + 16), 2'b10);
        chk("full_count", 64'(rob_count), 16);
        chk("full_rdy", 64'(rob_alloc_rdy), 0);
        step(0, 0, 0, 0, 2'b11, 0, 1, 32'hC0, 32'hC1, 0);
        idle(2);
        chk("rdy_after_retire", 64'(rob_alloc_rdy), 1);
        disp(2, 3, 4, 2'b11);

        // Flush with partially completed entries.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        disp(2, 1, 2, 2'b11);
        disp(2, 3, 4, 2'b11);
        disp(1, 9, 0, 2'b01);
        step(0, 0, 0, 0, 2'b11, 1, 2, 32'h11, 32'h22, 0);
        wb1(4, 32'h44);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        disp(1, 10, 0, 2'b01);

        // rfWrite=0 retirement, then reset while the retire slot is live.
        wb1(0, 32'h55);
        idle(1);
        disp(1, 12, 0, 2'b00);
        wb1(1, 32'h66);
        idle(1);
        #3;
        chk("ret_live", 64'(val_ret), 1);
        chk("ret_live_rfw", 64'(rfWrite_ret[0]), 0);
        do_reset();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            nd = $urandom_range(0, 2);
            cand.delete();
            for (int i = 0; i < q.size(); i++) if (!q[i].done) cand.push_back(i);
            wv = 0; ca = 0; cb = 0;
            if (cand.size() > 0 && $urandom_range(0, 1)) begin
                a = $urandom_range(0, cand.size() - 1);
                ca = (h + cand[a]) % ROB_DEPTH;
                wv[0] = 1;
                if (cand.size() > 1 && $urandom_range(0, 1)) begin
                    b = $urandom_range(0, cand.size() - 2);
                    if (b >= a) b++;
                    cb = (h + cand[b]) % ROB_DEPTH;
                    wv[1] = 1;
                end
            end
            step(nd, 5'($urandom), 5'($urandom), 2'($urandom), wv, ca, cb,
                 $urandom, $urandom, ($urandom_range(0, 49) == 0));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        chk("sb_drained", 64'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
